// File: rtl/cpu16_regs_ctl.sv
// Register-file access controller: round-robin sharing of the single write port
// between execute and load writeback, plus a stall/drain/access debug port.
module cpu16_regs_ctl #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_valid,
    input  logic [AW-1:0] ex_wsel,
    input  logic [DW-1:0] ex_wdata,
    output logic          ex_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_wsel,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ready,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_sel,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    input  logic [AW-1:0] cpu_asel,
    output logic          cpu_stall,
    output logic [AW-1:0] rf_asel,
    output logic [AW-1:0] rf_wsel,
    output logic          rf_wreg,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_adata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        RADDR = 3'd2,
        RDATA = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;          // 0: ex wins next contest, 1: ld wins
    logic          dbg_we_q, dbg_we_d;
    logic [AW-1:0] dbg_sel_q, dbg_sel_d;
    logic [DW-1:0] dbg_wdata_q, dbg_wdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic arb_en, ex_gnt, ld_gnt;

    // Writebacks are only served while the core may still own the port.
    always_comb begin
        arb_en = !reset && (state_q == IDLE || state_q == DRAIN);
        ex_gnt = arb_en && ex_valid && (!ld_valid || !rr_q);
        ld_gnt = arb_en && ld_valid && (!ex_valid ||  rr_q);
        rr_d   = (arb_en && ex_valid && ld_valid) ? ~rr_q : rr_q;
    end

    always_comb begin
        ex_ready = ex_gnt;
        ld_ready = ld_gnt;
        rf_wreg  = ex_gnt || ld_gnt;
        rf_wsel  = ld_gnt ? ld_wsel  : ex_wsel;
        rf_wdata = ld_gnt ? ld_wdata : ex_wdata;
        if (state_q == WRITE) begin
            rf_wreg  = 1'b1;
            rf_wsel  = dbg_sel_q;
            rf_wdata = dbg_wdata_q;
        end
        rf_asel   = (state_q == RADDR) ? dbg_sel_q : cpu_asel;
        dbg_rdata = dbg_rdata_q;
    end

    always_comb begin
        state_d     = state_q;
        cpu_stall   = 1'b1;
        dbg_ack     = 1'b0;
        dbg_we_d    = dbg_we_q;
        dbg_sel_d   = dbg_sel_q;
        dbg_wdata_d = dbg_wdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                cpu_stall = dbg_req;
                if (dbg_req) begin
                    dbg_we_d    = dbg_we;
                    dbg_sel_d   = dbg_sel;
                    dbg_wdata_d = dbg_wdata;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (!ex_valid && !ld_valid)
                    state_d = dbg_we_q ? WRITE : RADDR;
            end
            RADDR: state_d = RDATA;
            RDATA: begin
                dbg_rdata_d = rf_adata;
                state_d     = DONE;
            end
            WRITE: state_d = DONE;
            DONE: begin
                dbg_ack = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            dbg_we_q    <= 1'b0;
            dbg_sel_q   <= '0;
            dbg_wdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            dbg_we_q    <= dbg_we_d;
            dbg_sel_q   <= dbg_sel_d;
            dbg_wdata_q <= dbg_wdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule
